// File: rtl/div32_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// Ports: master drives start/is_signed/dividend/divisor; slave drives busy/done/results.
interface div32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div32_seq.sv
// Restoring shift-subtract divider for DIV/DIVU, one quotient bit per clock.
// Ports: clk, reset (async high), bus (div32_seq_if.slave: start/busy/done/results).
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    div32_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] orig_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH:0]   r_r;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t_sub;
    logic [4:0]       cnt;
    logic             sq;
    logic             sr;
    logic             dz;
    logic             dz_r;
    logic             done_r;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // 0x80000000 negates to itself, which is the right unsigned magnitude.
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        if (bus.is_signed && bus.dividend[WIDTH-1])
            a_mag = -bus.dividend;
        if (bus.is_signed && bus.divisor[WIDTH-1])
            b_mag = -bus.divisor;
    end

    // Trial subtract as R' + ~{0,D} + 1; bit WIDTH set means borrow.
    always_comb begin
        r_sh  = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
        t_sub = r_sh + {1'b1, ~d_r} + ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (cnt == 5'd31) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r    <= '0;
            d_r    <= '0;
            orig_r <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            r_r    <= '0;
            cnt    <= '0;
            sq     <= 1'b0;
            sr     <= 1'b0;
            dz     <= 1'b0;
            dz_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_r    <= a_mag;
                        d_r    <= b_mag;
                        orig_r <= bus.dividend;
                        sq     <= bus.is_signed &
                                  (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        sr     <= bus.is_signed & bus.dividend[WIDTH-1];
                        dz     <= (bus.divisor == '0);
                        r_r    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    q_r <= {q_r[WIDTH-2:0], ~t_sub[WIDTH]};
                    r_r <= t_sub[WIDTH] ? r_sh : t_sub;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    done_r <= 1'b1;
                    dz_r   <= dz;
                    if (dz) begin
                        quo_r <= '1;
                        rem_r <= orig_r;
                    end else begin
                        quo_r <= sq ? -q_r : q_r;
                        rem_r <= sr ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq.
// Drives the master side of div32_seq_if and checks results, latency and handshake.
module tb_div32_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    div32_seq_if bus ();

    div32_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Starts a division from a negedge; returns at the negedge where done
    // is seen (lat = cycles after the accepting edge, -1 on timeout).
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int bcnt);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) lat = -1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b exp 000",
                     {bus.busy, bus.done, bus.div_by_zero});
        end
        tests++;
        if ({bus.quotient, bus.remainder} !== 64'd0) begin
            fails++;
            $display("FAIL reset_results got %h %h exp 0 0", bus.quotient, bus.remainder);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat, bc;
        run_div(1'b0, 32'd100, 32'd7, lat, bc);
        tests++;
        if (lat !== 33) begin
            fails++;
            $display("FAIL udiv_latency got %0d exp 33", lat);
        end
        tests++;
        if (bc !== 33) begin
            fails++;
            $display("FAIL udiv_busy_cycles got %0d exp 33", bc);
        end
        tests++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL udiv_result got %h %h %b exp e 2 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL udiv_busy_at_done got %b exp 0", bus.busy);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL udiv_done_pulse got %b exp 0", bus.done);
        end
    endtask

    task automatic test_signed();
        int lat, bc;
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, bc);
        tests++;
        if (bus.quotient !== 32'hFFFFFFFD || bus.remainder !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL sdiv_neg_dividend got %h %h exp fffffffd ffffffff",
                     bus.quotient, bus.remainder);
        end
        @(negedge clk);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, bc);
        tests++;
        if (bus.quotient !== 32'hFFFFFFFD || bus.remainder !== 32'd1) begin
            fails++;
            $display("FAIL sdiv_neg_divisor got %h %h exp fffffffd 1",
                     bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_edges();
        int lat, bc;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        tests++;
        if (bus.quotient !== 32'h80000000 || bus.remainder !== 32'd0) begin
            fails++;
            $display("FAIL edge_intmin got %h %h exp 80000000 0",
                     bus.quotient, bus.remainder);
        end
        @(negedge clk);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, lat, bc);
        tests++;
        if (bus.quotient !== 32'hFFFFFFFF || bus.remainder !== 32'd0) begin
            fails++;
            $display("FAIL edge_max_by_1 got %h %h exp ffffffff 0",
                     bus.quotient, bus.remainder);
        end
        @(negedge clk);
        run_div(1'b0, 32'd5, 32'd9, lat, bc);
        tests++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 32'd5) begin
            fails++;
            $display("FAIL edge_small got %h %h exp 0 5", bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_div(1'b1, 32'hFFFF1234, 32'd0, lat, bc);
        tests++;
        if (lat !== 33) begin
            fails++;
            $display("FAIL dz_latency got %0d exp 33", lat);
        end
        tests++;
        if (bus.quotient !== 32'hFFFFFFFF || bus.remainder !== 32'hFFFF1234) begin
            fails++;
            $display("FAIL dz_result got %h %h exp ffffffff ffff1234",
                     bus.quotient, bus.remainder);
        end
        tests++;
        if (bus.div_by_zero !== 1'b1) begin
            fails++;
            $display("FAIL dz_flag got %b exp 1", bus.div_by_zero);
        end
        @(negedge clk);
        run_div(1'b0, 32'd9, 32'd4, lat, bc);
        tests++;
        if (bus.div_by_zero !== 1'b0 || bus.quotient !== 32'd2 || bus.remainder !== 32'd1) begin
            fails++;
            $display("FAIL dz_clear got %b %h %h exp 0 2 1",
                     bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int k;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            if (k == 4) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b1;
                bus.dividend  = 32'd50;
                bus.divisor   = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        tests++;
        if (k !== 33) begin
            fails++;
            $display("FAIL ignore_latency got %0d exp 33", k);
        end
        tests++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            fails++;
            $display("FAIL ignore_result got %h %h exp e 2", bus.quotient, bus.remainder);
        end
    endtask

    // Entered at the done negedge of the previous operation.
    task automatic test_back_to_back();
        int k;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd50;
        bus.divisor   = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept got done=%b busy=%b exp 0 1", bus.done, bus.busy);
        end
        tests++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            fails++;
            $display("FAIL b2b_hold got %h %h exp e 2", bus.quotient, bus.remainder);
        end
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k !== 33) begin
            fails++;
            $display("FAIL b2b_latency got %0d exp 33", k);
        end
        tests++;
        if (bus.quotient !== 32'd10 || bus.remainder !== 32'd0) begin
            fails++;
            $display("FAIL b2b_result got %h %h exp a 0", bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, bc, seen;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            fails++;
            $display("FAIL abort_flags got %b exp 000",
                     {bus.busy, bus.done, bus.div_by_zero});
        end
        tests++;
        if ({bus.quotient, bus.remainder} !== 64'd0) begin
            fails++;
            $display("FAIL abort_results got %h %h exp 0 0", bus.quotient, bus.remainder);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_done got %0d active cycles exp 0", seen);
        end
        run_div(1'b0, 32'd100, 32'd7, lat, bc);
        tests++;
        if (lat !== 33 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            fails++;
            $display("FAIL abort_restart got lat=%0d %h %h exp 33 e 2",
                     lat, bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_edges();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div32_seq.md
# div32_seq

Multi-cycle 32-bit integer divider for the toy MIPS datapath, executing DIV and DIVU. It computes quotient (to LO) and remainder (to HI) by restoring shift-subtract, one quotient bit per clock, behind a start/busy/done handshake. It sits beside the ALU, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a division. Sampled only when idle.
- `is_signed` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `dividend` input 32: sampled on the accepting edge.
- `divisor` input 32: sampled on the accepting edge.
- `busy` output 1: high while a division is in progress.
- `done` output 1: one-cycle pulse when results are valid.
- `quotient` output 32: LO result, held until the next accepted start.
- `remainder` output 32: HI result, held until the next accepted start.
- `div_by_zero` output 1: divisor was zero for the current result; held with the results.

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - CALC: 32 iterations, 5-bit counter.
  - FIX: sign correction and output write.
- IDLE → CALC on `start` = 1. The start edge does the following:
  - Latch the magnitudes: `|dividend|` and `|divisor|` when `is_signed`, raw operands otherwise. The magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - Latch the sign flags `sq` = dividend[31] XOR divisor[31] and `sr` = dividend[31]. Both are forced to 0 when unsigned.
  - Latch `dz` = (divisor == 0) and the original dividend.
  - Clear the partial remainder R (33 bits) and the counter.
  - Clear `done`.
- CALC, each cycle:
  - R' = {R[31:0], Q[31]} and Q = Q << 1.
  - T = R' − {1'b0, D}, computed as a 33-bit add of ~D plus carry-in 1.
  - If T[32] = 0 (no borrow): R = T and Q[0] = 1. Otherwise R = R' and Q[0] = 0.
  - After the 32nd iteration (counter = 31), go to FIX.
- FIX, one cycle, then → IDLE:
  - `quotient` = `sq` ? −Q : Q.
  - `remainder` = `sr` ? −R[31:0] : R[31:0].
  - If `dz`: `quotient` = 0xFFFFFFFF and `remainder` = the original dividend, regardless of signedness. `div_by_zero` = 1.
  - Otherwise `div_by_zero` = 0.
  - Set `done` = 1.
- `start` while busy (CALC or FIX) is ignored. No queuing.
- Signed INT_MIN / −1 gives quotient 0x80000000 and remainder 0 (wraps). No overflow flag is raised.
- Remainder sign always follows the dividend, and the quotient truncates toward zero (MIPS semantics).

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0, and all internal registers 0.
- Reset asserted mid-operation aborts immediately to reset values. No `done` is produced for the aborted operation.
- Edge E0 accepts `start`. `busy` = 1 from after E0 until E33.
- CALC occupies E1..E32. FIX is at E33.
- After E33: `done` = 1, `busy` = 0, and results are valid. Latency is fixed at 33 cycles, including divide-by-zero.
- `done` returns to 0 at E34, whether or not a new start is taken.
- `start` high during the `done` cycle is accepted at E34 (back-to-back allowed).
- When `start` is accepted, `quotient`, `remainder` and `div_by_zero` keep their old values until the new FIX edge.

## Test plan
- Unsigned: 100 / 7 with `is_signed` = 0, `start` at E0 → `done` high in the cycle after E33 only, `quotient` = 14, `remainder` = 2, `div_by_zero` = 0. `busy` is high for exactly 33 cycles.
- Signed: −7 / 2 (0xFFFFFFF9 / 2) → `quotient` = 0xFFFFFFFD, `remainder` = 0xFFFFFFFF. Then 7 / −2 → `quotient` = 0xFFFFFFFD, `remainder` = 1.
- Edge values:
  - Signed 0x80000000 / 0xFFFFFFFF → `quotient` = 0x80000000, `remainder` = 0.
  - Unsigned 0xFFFFFFFF / 1 → `quotient` = 0xFFFFFFFF, `remainder` = 0.
  - Unsigned 5 / 9 → `quotient` = 0, `remainder` = 5.
- Divide by zero: signed 0xFFFF1234 / 0 → `quotient` = 0xFFFFFFFF, `remainder` = 0xFFFF1234, `div_by_zero` = 1, at the same 33-cycle latency. The next non-zero division clears `div_by_zero`.
- Handshake:
  - Pulse `start` with new operands at E5 of an ongoing 100 / 7 → ignored; results remain 14 and 2.
  - Hold `start` during the `done` cycle with 50 / 5 → second `done` 33 cycles later with `quotient` = 10, `remainder` = 0.
- Reset: assert `reset` asynchronously between edges at cycle 10 of a division → `busy`, `done`, `quotient`, `remainder` and `div_by_zero` go to 0 immediately, and no `done` pulse follows. A new `start` after reset release completes normally.
